// File: rtl/mux4_16_reg.sv
// ============================================================================
// Module   : mux4_16_reg
// Brief    : Registered 4:1 multiplexer; selects one of four data words and
//            presents it from a flop one cycle later.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mux4_16_reg #(
    parameter int WIDTH = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [1:0]       sel_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [WIDTH-1:0] c_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] y_o
);

    localparam logic [1:0] c_SEL_A = 2'b00;
    localparam logic [1:0] c_SEL_B = 2'b01;
    localparam logic [1:0] c_SEL_C = 2'b10;
    localparam logic [1:0] c_SEL_D = 2'b11;

    generate
        if (WIDTH < 1) begin : g_width_check
            $error("mux4_16_reg: WIDTH must be >= 1");
        end
    endgenerate

    logic [WIDTH-1:0] w_mux;
    logic [WIDTH-1:0] r_y;

    always_comb begin
        w_mux = a_i;
        case (sel_i)
            c_SEL_A: w_mux = a_i;
            c_SEL_B: w_mux = b_i;
            c_SEL_C: w_mux = c_i;
            c_SEL_D: w_mux = d_i;
            default: w_mux = a_i;
        endcase
    end

    // Reset wins over selection so a reset edge always yields all-zero output.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_y <= '0;
        end else begin
            r_y <= w_mux;
        end
    end

    assign y_o = r_y;

endmodule

`default_nettype wire

// File: tb/tb_mux4_16_reg.sv
// ============================================================================
// Module   : tb_mux4_16_reg
// Brief    : Self-checking scoreboard bench for mux4_16_reg.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mux4_16_reg;

    localparam int c_W = 16;

    logic           clk;
    logic           rst;
    logic [1:0]     sel;
    logic [c_W-1:0] a, b, c, d;
    logic [c_W-1:0] y;

    int n_cmp = 0;
    int n_bad = 0;
    logic [c_W-1:0] exp_q[$];

    mux4_16_reg #(.WIDTH(c_W)) u_dut (
        .clk_i (clk),
        .rst_i (rst),
        .sel_i (sel),
        .a_i   (a),
        .b_i   (b),
        .c_i   (c),
        .d_i   (d),
        .y_o   (y)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [c_W-1:0] obs, input logic [c_W-1:0] expv);
        n_cmp++;
        if (obs !== expv) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, expv);
        end
    endtask

    function automatic logic [c_W-1:0] model(input logic r, input logic [1:0] s,
                                             input logic [c_W-1:0] va, input logic [c_W-1:0] vb,
                                             input logic [c_W-1:0] vc, input logic [c_W-1:0] vd);
        if (r) return '0;
        case (s)
            2'd0: return va;
            2'd1: return vb;
            2'd2: return vc;
            default: return vd;
        endcase
    endfunction

    // Drive one cycle of stimulus mid-low-phase, then compare just after the edge.
    task automatic step(input string tag, input logic r, input logic [1:0] s,
                        input logic [c_W-1:0] va, input logic [c_W-1:0] vb,
                        input logic [c_W-1:0] vc, input logic [c_W-1:0] vd);
        @(negedge clk);
        rst = r; sel = s; a = va; b = vb; c = vc; d = vd;
        exp_q.push_back(model(r, s, va, vb, vc, vd));
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) check({tag, "_empty"}, y, ~y);
        else check(tag, y, exp_q.pop_front());
    endtask

    initial begin
        rst = 1'b1; sel = 2'b11;
        a = 16'h1111; b = 16'h2222; c = 16'h3333; d = 16'h4444;

        step("reset0", 1'b1, 2'b11, 16'h1111, 16'h2222, 16'h3333, 16'h4444);
        step("reset1", 1'b1, 2'b11, 16'h1111, 16'h2222, 16'h3333, 16'h4444);

        step("sel00", 1'b0, 2'b00, 16'h1111, 16'h2222, 16'h3333, 16'h4444);
        step("sel01", 1'b0, 2'b01, 16'h1111, 16'h2222, 16'h3333, 16'h4444);
        step("sel10", 1'b0, 2'b10, 16'h1111, 16'h2222, 16'h3333, 16'h4444);
        step("sel11", 1'b0, 2'b11, 16'h1111, 16'h2222, 16'h3333, 16'h4444);

        // Select change between edges must not reach the output early.
        step("lat_sel00", 1'b0, 2'b00, 16'h1111, 16'h2222, 16'h3333, 16'h4444);
        #1 sel = 2'b10;
        #2 check("lat_hold", y, 16'h1111);
        step("lat_sel10", 1'b0, 2'b10, 16'h1111, 16'h2222, 16'h3333, 16'h4444);

        step("bdat_aaaa", 1'b0, 2'b01, 16'h1111, 16'hAAAA, 16'h3333, 16'h4444);
        step("bdat_5555", 1'b0, 2'b01, 16'h1111, 16'h5555, 16'h3333, 16'h4444);
        step("unsel_chg", 1'b0, 2'b01, 16'hDEAD, 16'h5555, 16'hBEEF, 16'hCAFE);
        step("unsel_chg2", 1'b0, 2'b01, 16'h0F0F, 16'h5555, 16'hF0F0, 16'h1234);

        step("bnd_ffff", 1'b0, 2'b00, 16'hFFFF, 16'h2222, 16'h3333, 16'h4444);
        step("bnd_8000", 1'b0, 2'b00, 16'h8000, 16'h2222, 16'h3333, 16'h4444);
        step("bnd_0001", 1'b0, 2'b00, 16'h0001, 16'h2222, 16'h3333, 16'h4444);
        step("bnd_d_ffff", 1'b0, 2'b11, 16'h0001, 16'h2222, 16'h3333, 16'hFFFF);

        step("mid_s0", 1'b0, 2'b00, 16'h1111, 16'h2222, 16'h3333, 16'h4444);
        step("mid_s1", 1'b0, 2'b01, 16'h1111, 16'h2222, 16'h3333, 16'h4444);
        step("mid_rst", 1'b1, 2'b10, 16'h1111, 16'h2222, 16'h3333, 16'h4444);
        step("mid_s3", 1'b0, 2'b11, 16'h1111, 16'h2222, 16'h3333, 16'h4444);

        // A reset pulse confined to the low phase must be ignored.
        @(negedge clk);
        sel = 2'b10;
        exp_q.push_back(16'h3333);
        rst = 1'b1;
        #2 rst = 1'b0;
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) check("glitch_empty", y, ~y);
        else check("rst_glitch", y, exp_q.pop_front());

        for (int i = 0; i < 40; i++) begin
            step("rand", ($urandom_range(0, 9) == 0), 2'($urandom_range(0, 3)),
                 16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom));
        end

        if (exp_q.size() != 0) check("q_drain", 16'(exp_q.size()), 16'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/mux4_16_reg.md
Name: mux4_16_reg

Overview:
- Registered 4:1 multiplexer for Width-bit data words, default 16 bits.
- Selects one of four input buses (a_i, b_i, c_i, d_i) with a 2-bit select and registers the result on the rising clock edge.
- Used as a leaf datapath element. The output is a clean flop output, safe for downstream timing.

Parameters:
- Width, 16, data width in bits of a_i, b_i, c_i, d_i and y_o. Legal range >= 1. An elaboration-time check rejects Width < 1.

Ports:
- clk_i  input  1  single clock; all state updates on rising edge.
- rst_i  input  1  synchronous, active-high reset.
- sel_i  input  2  select: 2'b00=a_i, 2'b01=b_i, 2'b10=c_i, 2'b11=d_i.
- a_i  input  Width  data input 0.
- b_i  input  Width  data input 1.
- c_i  input  Width  data input 2.
- d_i  input  Width  data input 3.
- y_o  output  Width  registered selected data.

Behaviour:
- Single clock domain (clk_i). Reset is synchronous and active-high (rst_i). Only the rising edge of clk_i is sampled.
- Reset:
  - If rst_i=1 at a rising edge, y_o <= '0 (all Width bits zero), regardless of sel_i or the data inputs.
  - rst_i has priority over selection.
  - An asynchronous rst_i pulse that does not span a rising edge has no effect.
- Normal operation, at each rising edge with rst_i=0:
  - sel_i=00: y_o <= a_i.
  - sel_i=01: y_o <= b_i.
  - sel_i=10: y_o <= c_i.
  - sel_i=11: y_o <= d_i.
- Latency:
  - Exactly 1 clock cycle from sel_i and data sampled at edge N to y_o valid after edge N.
  - y_o holds stable between edges.
  - No combinational path from any input to y_o.
- Select changes: sel_i may change every cycle. Each edge independently selects per the sampled sel_i. There is no state other than the output register.
- X/Z on sel_i: out-of-range values are impossible with 2 bits. The implementation uses a full case with a default branch that drives the a_i path, so no latch is inferred.
- Reset mid-operation: asserting rst_i on any edge clears y_o on that edge. On the first edge with rst_i=0, y_o reflects the selected input sampled at that edge.
- Power-up: y_o is undefined until the first reset edge. The bench must apply reset first.
- Width rules:
  - All data paths are exactly Width bits; no extension or truncation.
  - MSB and LSB pass unchanged, including all-ones values (e.g. 16'hFFFF).
- No handshake, no valid/ready, no internal FSM.

Test Plan:
- Reset: drive a_i=16'h1111, b_i=16'h2222, c_i=16'h3333, d_i=16'h4444, sel_i=2'b11, rst_i=1 for 2 edges -> y_o=16'h0000 after each edge.
- Select sweep: release reset, keep the same data, sel_i=00,01,10,11 on consecutive edges -> y_o = 1111, 2222, 3333, 4444, each one cycle after its select is sampled.
- Latency/no comb path: change sel_i from 00 to 10 mid-cycle -> y_o unchanged (1111) until the next rising edge, then 3333.
- Data change with fixed select: sel_i=01, b_i changes 16'hAAAA -> 16'h5555 between edges -> y_o follows with 1-cycle latency. Changes on the unselected inputs a_i, c_i, d_i do not affect y_o.
- Boundary values: sel_i=00, a_i=16'hFFFF, then 16'h8000, then 16'h0001 -> y_o reproduces each exactly, proving full-width pass-through.
- Reset mid-stream: while sel_i cycles with nonzero data, assert rst_i for one edge -> y_o=16'h0000 on that edge. Deassert -> the next edge shows the selected input value.
